// File: rtl/tx_uart_pkg.sv
// ---------------------------------------------------------------------------
// tx_uart_pkg
// Shared definitions for the host-link UART transmitter: FSM state encoding
// and 8N1 frame constants.
// ---------------------------------------------------------------------------
package tx_uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  localparam int   DATA_BITS  = 8;
  localparam int   BIT_IDX_W  = $clog2(DATA_BITS);
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tx_uart_baud_tick.sv
// ---------------------------------------------------------------------------
// baud_tick
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps to 0;
// `last` is high for the single cycle where the count is CLKS_PER_BIT-1,
// which is the final cycle of the current UART bit.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   clr    in   synchronous clear, holds the count at 0
//   last   out  final cycle of the current bit period
// ---------------------------------------------------------------------------
module baud_tick #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic last
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == LAST_CNT);

  always_comb begin
    if (clr || last) cnt_d = '0;
    else             cnt_d = cnt_q + CW'(1);
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge value of every other register, independent of process order.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tx_uart.sv
// ---------------------------------------------------------------------------
// tx_uart
// Drains a first-word-fall-through tx FIFO and shifts each byte out on the
// host-link UART line as 8N1, LSB first. Frames go back to back while the
// FIFO has data: the pop for the next byte happens on the final cycle of the
// current stop bit, so the next start bit follows with no idle gap.
//
// Build option: define TX_UART_PARITY_EN to insert an even-parity bit after
// data bit 7 (11-bit frame). Undefined, the frame is plain 8N1 (10 bits).
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous active-low reset
//   rdata   in   [7:0] FIFO head byte, valid while rempty=0
//   rempty  in   FIFO empty
//   rinc    out  FIFO pop strobe (combinational, one cycle per byte)
//   tx      out  registered serial line, idle high
//   busy    out  frame in progress (state != IDLE)
// ---------------------------------------------------------------------------
module tx_uart
  import tx_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] rdata,
  input  logic                 rempty,
  output logic                 rinc,
  output logic                 tx,
  output logic                 busy
);

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic                   tx_q, tx_d;
  logic                   bit_last;
  logic [BIT_IDX_W-1:0]   next_idx;

  // The counter is held at 0 while idle so the start bit always gets a full
  // period; between bits it simply wraps.
  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == IDLE),
    .last (bit_last)
  );

  assign next_idx = bit_idx_q + BIT_IDX_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state logic. tx_d is the level for the next cycle, so the line
  // changes on the same edge as the state it belongs to.
  always_comb begin
    // NOTE: every output of this block is defaulted first; without it a path
    // that skips an assignment would infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;

    case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (!rempty) begin
          shift_d = rdata;
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (bit_last) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end

      DATA: begin
        if (bit_last) begin
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef TX_UART_PARITY_EN
            state_d = PARITY;
            tx_d    = ^shift_q;
`else
            state_d = STOP;
            tx_d    = STOP_LEVEL;
`endif
          end else begin
            bit_idx_d = next_idx;
            tx_d      = shift_q[next_idx];
          end
        end
      end

`ifdef TX_UART_PARITY_EN
      PARITY: begin
        if (bit_last) begin
          state_d = STOP;
          tx_d    = STOP_LEVEL;
        end
      end
`endif

      STOP: begin
        if (bit_last) begin
          if (!rempty) begin
            // Chain straight into the next frame.
            shift_d = rdata;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = IDLE_LEVEL;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
  end

  // Outputs. rinc mirrors exactly the two transitions that latch rdata.
  always_comb begin
    rinc = 1'b0;
    if (rst_n && !rempty) begin
      if (state_q == IDLE)                rinc = 1'b1;
      else if (state_q == STOP && bit_last) rinc = 1'b1;
    end
  end

  assign busy = (state_q != IDLE);
  assign tx   = tx_q;

endmodule

// File: tb/tb_tx_uart.sv
// ---------------------------------------------------------------------------
// tb_tx_uart
// Scoreboard bench for tx_uart with CLKS_PER_BIT=4. Bytes offered to a FIFO
// model are pushed into an expected queue; an independent line monitor
// decodes every frame on tx and compares it against the queue head.
// Cycle-level properties (pop pulses, busy length, latency) are checked by
// the directed sequence.
// ---------------------------------------------------------------------------
module tb_tx_uart;

  localparam int CPB = 4;
`ifdef TX_UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 10 + PAR;
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rdata;
  logic       rempty;
  logic       rinc;
  logic       tx;
  logic       busy;

  tx_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdata (rdata),
    .rempty(rempty),
    .rinc  (rinc),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic       pop_pending = 1'b0;

  function automatic void refresh();
    rempty = (fq.size() == 0);
    rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
    refresh();
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pop strobe tracker (sampled mid-cycle) and FIFO pop after the edge.
  int rinc_stamps[$];
  initial forever begin
    @(negedge clk);
    pop_pending = rst_n && rinc;
    if (pop_pending) rinc_stamps.push_back(cyc);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (pop_pending && fq.size() != 0) void'(fq.pop_front());
    pop_pending = 1'b0;
    refresh();
  end

  // busy run-length tracker
  int busy_run = 0;
  int last_busy_len = 0;
  initial forever begin
    @(negedge clk);
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy_len = busy_run;
      busy_run      = 0;
    end
  end

  // ---------------- line monitor ----------------
  logic       mon_active = 1'b0;
  int         mon_pos, mon_bad;
  logic [7:0] mon_data;
  logic       mon_par;
  int         start_stamps[$];

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      // A frame cut by reset is dropped by the design; drop it here too.
      if (mon_active && exp_q.size() != 0) void'(exp_q.pop_front());
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx == 1'b0) begin
        mon_active = 1'b1;
        mon_pos    = 0;
        mon_bad    = 0;
        mon_data   = 8'h00;
        mon_par    = 1'b0;
        start_stamps.push_back(cyc);
      end
      if (mon_active) begin
        int bn, sub;
        bn  = mon_pos / CPB;
        sub = mon_pos % CPB;
        if (bn == 0) begin
          if (tx !== 1'b0) mon_bad++;
        end else if (bn <= 8) begin
          if (sub == 0) mon_data[bn-1] = tx;
          else if (tx !== mon_data[bn-1]) mon_bad++;
        end else if (PAR == 1 && bn == 9) begin
          if (sub == 0) mon_par = tx;
          else if (tx !== mon_par) mon_bad++;
        end else begin
          if (tx !== 1'b1) mon_bad++;
        end
        mon_pos++;
        if (mon_pos == FRAME) begin
          logic [7:0] e;
          mon_active = 1'b0;
          check("frame_expected", int'(exp_q.size() != 0), 1);
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
          check("frame_data", int'(mon_data), int'(e));
          check("frame_shape", mon_bad, 0);
          if (PAR == 1) check("frame_parity", int'(mon_par), int'(^e));
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || fq.size() != 0 || mon_active) && n < 1000);
    check("idle_reached", int'(n < 1000), 1);
    tick(1);
  endtask

  // ---------------- directed sequence ----------------
  int base, bl;

  initial begin
    rst_n = 1'b0;
    refresh();

    // Reset held 3 cycles with data waiting.
    push_byte(8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", int'(tx), 1);
      check("rst_rinc", int'(rinc), 0);
      check("rst_busy", int'(busy), 0);
    end
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rinc_after_release", int'(rinc), 1);
    wait_idle();

    // Single byte 0xA5: latency, single pop, busy length.
    base = rinc_stamps.size();
    push_byte(8'hA5);
    @(negedge clk);
    check("single_rinc_same_cycle", int'(rinc), 1);
    @(negedge clk);
    check("single_start_next_cycle", int'(tx), 0);
    wait_idle();
    check("single_pop_count", rinc_stamps.size() - base, 1);
    check("single_busy_len", last_busy_len, FRAME);
    check("single_idle_tx", int'(tx), 1);

    // Back-to-back 0x00, 0xFF.
    base = rinc_stamps.size();
    bl   = start_stamps.size();
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_idle();
    check("b2b_pop_count", rinc_stamps.size() - base, 2);
    check("b2b_pop_spacing", rinc_stamps[base+1] - rinc_stamps[base], FRAME);
    check("b2b_start_spacing", start_stamps[bl+1] - start_stamps[bl], FRAME);
    check("b2b_busy_len", last_busy_len, 2 * FRAME);

    // Parity / frame length with 0x07.
    push_byte(8'h07);
    wait_idle();
    check("p07_busy_len", last_busy_len, FRAME);

    // FIFO fills mid-frame during DATA.
    base = rinc_stamps.size();
    push_byte(8'h5A);
    tick(12);
    push_byte(8'hC3);
    tick(4);
    check("mid_no_early_pop", rinc_stamps.size() - base, 1);
    wait_idle();
    check("mid_pop_count", rinc_stamps.size() - base, 2);
    check("mid_pop_at_stop_end", rinc_stamps[base+1] - rinc_stamps[base], FRAME);
    check("mid_busy_len", last_busy_len, 2 * FRAME);

    // Reset during data bit 3.
    base = rinc_stamps.size();
    push_byte(8'h96);
    tick(18);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_tx", int'(tx), 1);
    check("mrst_busy", int'(busy), 0);
    tick(20);
    check("mrst_no_repop", rinc_stamps.size() - base, 1);
    check("mrst_idle_tx", int'(tx), 1);
    push_byte(8'h11);
    wait_idle();
    check("mrst_resume_pop", rinc_stamps.size() - base, 2);

    check("all_frames_seen", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
